input_fifo_wconv: RTL and testbench

Parametrised single-clock successor to the fixed 16-in/8-out input FIFO chain. Accepts IN_WIDTH-bit words from the USB/inouttraffic side and delivers OUT_WIDTH-bit sub-words to the cracking core, with first-word fall-through output. Adds four features the fixed chain lacks: runtime-agnostic width ratio, a programmable full threshold parameter, an output-unit fill level, and sticky overflow/underflow flags. Sits between the USB write path and the core input buffers in every fpga-* design.

---
 rtl/input_fifo_pkg.sv | 45 ++++
 rtl/input_fifo_wconv_mem.sv | 40 ++++
 rtl/input_fifo_wconv.sv | 143 ++++++++++++++
 tb/tb_input_fifo_wconv.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/input_fifo_pkg.sv
// Shared helpers for the width-converting input FIFO: sizing functions and
// the parameter legality check used at elaboration.
package input_fifo_pkg;

    // Ceiling log2 evaluated at elaboration; clog2(1) is 0.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    function automatic bit isPow2(input int value);
        return (value > 0) && ((value & (value - 1)) == 0);
    endfunction

    // Width of one sub-word delivered to the core.
    function automatic int outWidth(input int inWidth, input int ratio);
        return inWidth / ratio;
    endfunction

    // Pointers carry one extra wrap bit so full and empty differ.
    function automatic int ptrWidth(input int depth);
        return clog2(depth) + 1;
    endfunction

    // Level counts sub-words, so it must reach DEPTH*RATIO inclusive.
    function automatic int lvlWidth(input int depth, input int ratio);
        return clog2(depth * ratio) + 1;
    endfunction

    // sub_idx needs at least one bit even when RATIO is 1.
    function automatic int subWidth(input int ratio);
        return (ratio > 1) ? clog2(ratio) : 1;
    endfunction

    function automatic bit paramsOk(input int inWidth, input int ratio,
                                    input int depth, input int progThresh);
        return isPow2(ratio) && (ratio <= 8) && isPow2(depth) && (depth >= 4)
            && ((inWidth % ratio) == 0) && (progThresh >= 1) && (progThresh <= depth);
    endfunction

endpackage

// File: rtl/input_fifo_wconv_mem.sv
// Simple dual-port storage for the input FIFO. The read port is registered;
// a write to the address being read is forwarded so a word written into an
// empty FIFO becomes the head on the very next cycle.
module fifo_mem_sdp
    import input_fifo_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_wrEn,
    input  logic [ADDR_W-1:0] i_wrAddr,
    input  logic [WIDTH-1:0]  i_wrData,
    input  logic [ADDR_W-1:0] i_rdAddr,
    output logic [WIDTH-1:0]  o_rdData
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdData;

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (i_wrEn) begin
            r_mem[i_wrAddr] <= i_wrData;
        end
    end

    // Registered read with write-to-same-address forwarding.
    always_ff @(posedge clk) begin
        if (i_wrEn && (i_wrAddr == i_rdAddr)) begin
            r_rdData <= i_wrData;
        end else begin
            r_rdData <= r_mem[i_rdAddr];
        end
    end

    assign o_rdData = r_rdData;

endmodule

// File: rtl/input_fifo_wconv.sv
// Width-converting first-word-fall-through input FIFO: IN_WIDTH-bit words in,
// IN_WIDTH/RATIO-bit sub-words out, with registered flags, a sub-word level
// and sticky overflow/underflow indicators.
module input_fifo_wconv
    import input_fifo_pkg::*;
#(
    parameter int IN_WIDTH         = 16,
    parameter int RATIO            = 2,
    parameter int DEPTH            = 2048,
    parameter int PROG_FULL_THRESH = 1024,
    parameter int LSB_FIRST        = 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [IN_WIDTH-1:0]                  din,
    input  logic                                 wr_en,
    output logic                                 full,
    output logic                                 almost_full,
    output logic                                 prog_full,
    input  logic                                 rd_en,
    output logic [outWidth(IN_WIDTH, RATIO)-1:0] dout,
    output logic                                 empty,
    output logic [lvlWidth(DEPTH, RATIO)-1:0]    level,
    output logic                                 overflow,
    output logic                                 underflow
);

    localparam int OUT_WIDTH = outWidth(IN_WIDTH, RATIO);
    localparam int ADDR_W    = clog2(DEPTH);
    localparam int PTR_W     = ptrWidth(DEPTH);
    localparam int LVL_W     = lvlWidth(DEPTH, RATIO);
    localparam int SUB_W     = subWidth(RATIO);
    localparam int SUB_SHIFT = clog2(RATIO);

    generate
        if (!paramsOk(IN_WIDTH, RATIO, DEPTH, PROG_FULL_THRESH)) begin : g_badParams
            $error("input_fifo_wconv: illegal RATIO/DEPTH/IN_WIDTH/PROG_FULL_THRESH combination");
        end
    endgenerate

    logic [PTR_W-1:0]    r_wrPtr;
    logic [PTR_W-1:0]    r_rdPtr;
    logic [SUB_W-1:0]    r_subIdx;
    logic                r_full;
    logic                r_almostFull;
    logic                r_progFull;
    logic                r_empty;
    logic                r_overflow;
    logic                r_underflow;
    logic [LVL_W-1:0]    r_level;

    logic                w_wrAccept;
    logic                w_rdAccept;
    logic                w_pop;
    logic                w_memWe;
    logic [PTR_W-1:0]    w_wrPtrNext;
    logic [PTR_W-1:0]    w_rdPtrNext;
    logic [PTR_W-1:0]    w_usedNext;
    logic [SUB_W-1:0]    w_subIdxNext;
    logic [SUB_W-1:0]    w_sel;
    logic [LVL_W-1:0]    w_levelNext;
    logic [ADDR_W-1:0]   w_rdAddr;
    logic [IN_WIDTH-1:0] w_head;

    // Next-state pointers, sub-index and fill counts from the registered flags.
    always_comb begin
        w_wrAccept  = wr_en & ~r_full;
        w_rdAccept  = rd_en & ~r_empty;
        w_pop       = w_rdAccept && (r_subIdx == SUB_W'(RATIO - 1));
        w_wrPtrNext = r_wrPtr + PTR_W'(w_wrAccept);
        w_rdPtrNext = r_rdPtr + PTR_W'(w_pop);
        if (w_pop) begin
            w_subIdxNext = '0;
        end else if (w_rdAccept) begin
            w_subIdxNext = r_subIdx + 1'b1;
        end else begin
            w_subIdxNext = r_subIdx;
        end
        w_usedNext  = w_wrPtrNext - w_rdPtrNext;
        w_levelNext = (LVL_W'(w_usedNext) << SUB_SHIFT) - LVL_W'(w_subIdxNext);
        w_memWe     = w_wrAccept & rst_n;
        w_rdAddr    = rst_n ? w_rdPtrNext[ADDR_W-1:0] : '0;
    end

    fifo_mem_sdp #(
        .WIDTH  (IN_WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk      (clk),
        .i_wrEn   (w_memWe),
        .i_wrAddr (r_wrPtr[ADDR_W-1:0]),
        .i_wrData (din),
        .i_rdAddr (w_rdAddr),
        .o_rdData (w_head)
    );

    // Control state, registered flags and sticky error indicators.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wrPtr      <= '0;
            r_rdPtr      <= '0;
            r_subIdx     <= '0;
            r_full       <= 1'b0;
            r_almostFull <= 1'b0;
            r_progFull   <= 1'b0;
            r_empty      <= 1'b1;
            r_level      <= '0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_wrPtr      <= w_wrPtrNext;
            r_rdPtr      <= w_rdPtrNext;
            r_subIdx     <= w_subIdxNext;
            r_full       <= (w_usedNext == PTR_W'(DEPTH));
            r_almostFull <= (w_usedNext == PTR_W'(DEPTH - 1));
            r_progFull   <= (w_usedNext >= PTR_W'(PROG_FULL_THRESH));
            r_empty      <= (w_usedNext == '0);
            r_level      <= w_levelNext;
            if (wr_en && r_full) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && r_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    // Sub-word select from the registered head word and sub-index only.
    always_comb begin
        w_sel = (LSB_FIRST != 0) ? r_subIdx : (SUB_W'(RATIO - 1) - r_subIdx);
        dout  = w_head[w_sel*OUT_WIDTH +: OUT_WIDTH];
    end

    assign full        = r_full;
    assign almost_full = r_almostFull;
    assign prog_full   = r_progFull;
    assign empty       = r_empty;
    assign level       = r_level;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule

// File: tb/tb_input_fifo_wconv.sv
// Bench for input_fifo_wconv: two instances (LSB-first and MSB-first) share
// stimulus; a word-queue scoreboard predicts flags, level and sub-word order.
module tb_input_fifo_wconv;

    localparam int IW = 16;
    localparam int RT = 2;
    localparam int DP = 16;
    localparam int TH = 8;
    localparam int OW = IW / RT;
    localparam int LW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IW-1:0] din;
    logic          wr_en;
    logic          rd_en;

    logic          fullL, almostFullL, progFullL, emptyL, overflowL, underflowL;
    logic [OW-1:0] doutL;
    logic [LW-1:0] levelL;
    logic          fullM, almostFullM, progFullM, emptyM, overflowM, underflowM;
    logic [OW-1:0] doutM;
    logic [LW-1:0] levelM;

    int nChecks = 0;
    int nFail   = 0;

    logic [IW-1:0] modelQ[$];
    int            modelSub;
    bit            modelOv;
    bit            modelUn;

    typedef struct {
        logic          rst;
        logic          wr;
        logic [IW-1:0] d;
        logic          rd;
        logic          expEmpty;
        int            expLevel;
        logic [OW-1:0] expL;
        logic [OW-1:0] expM;
        logic          expUn;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    input_fifo_wconv #(
        .IN_WIDTH(IW), .RATIO(RT), .DEPTH(DP), .PROG_FULL_THRESH(TH), .LSB_FIRST(1)
    ) dutL (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .full(fullL),
        .almost_full(almostFullL), .prog_full(progFullL), .rd_en(rd_en), .dout(doutL),
        .empty(emptyL), .level(levelL), .overflow(overflowL), .underflow(underflowL)
    );

    input_fifo_wconv #(
        .IN_WIDTH(IW), .RATIO(RT), .DEPTH(DP), .PROG_FULL_THRESH(TH), .LSB_FIRST(0)
    ) dutM (
        .clk(clk), .rst_n(rst_n), .din(din), .wr_en(wr_en), .full(fullM),
        .almost_full(almostFullM), .prog_full(progFullM), .rd_en(rd_en), .dout(doutM),
        .empty(emptyM), .level(levelM), .overflow(overflowM), .underflow(underflowM)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, clock it, advance the scoreboard, then settle.
    task automatic applyStimulus(input logic rst, input logic wr, input logic [IW-1:0] d, input logic rd);
        int sz;
        rst_n = rst;
        wr_en = wr;
        din   = d;
        rd_en = rd;
        @(posedge clk);
        sz = modelQ.size();
        if (!rst) begin
            modelQ.delete();
            modelSub = 0;
            modelOv  = 1'b0;
            modelUn  = 1'b0;
        end else begin
            if (wr && sz == DP) modelOv = 1'b1;
            if (rd && sz == 0)  modelUn = 1'b1;
            if (rd && sz > 0) begin
                if (modelSub == RT - 1) begin
                    void'(modelQ.pop_front());
                    modelSub = 0;
                end else begin
                    modelSub++;
                end
            end
            if (wr && sz < DP) modelQ.push_back(d);
        end
        #1;
    endtask

    // Compare both instances against the scoreboard state.
    task automatic checkOutput();
        int            sz;
        logic [IW-1:0] head;
        sz = modelQ.size();
        checkVal("empty", emptyL, sz == 0);
        checkVal("full", fullL, sz == DP);
        checkVal("almost_full", almostFullL, sz == DP - 1);
        checkVal("prog_full", progFullL, sz >= TH);
        checkVal("overflow", overflowL, modelOv);
        checkVal("underflow", underflowL, modelUn);
        checkVal("levelL", levelL, sz * RT - modelSub);
        checkVal("levelM", levelM, sz * RT - modelSub);
        checkVal("emptyM", emptyM, sz == 0);
        if (sz > 0) begin
            head = modelQ[0];
            checkVal("doutL", doutL, OW'(head >> (modelSub * OW)));
            checkVal("doutM", doutM, OW'(head >> ((RT - 1 - modelSub) * OW)));
        end
    endtask

    task automatic step(input logic rst, input logic wr, input logic [IW-1:0] d, input logic rd);
        applyStimulus(rst, wr, d, rd);
        checkOutput();
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        rd_en    = 1'b0;
        din      = '0;
        modelSub = 0;
        modelOv  = 1'b0;
        modelUn  = 1'b0;

        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 8'h00, 8'h00, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 16'hA1B2, 1'b0, 1'b0, 2, 8'hB2, 8'hA1, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 8'hA1, 8'hB2, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 8'h00, 8'h00, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 8'h00, 8'h00, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 8'h00, 8'h00, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 2, 8'h34, 8'h12, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 16'h5678, 1'b1, 1'b0, 3, 8'h12, 8'h34, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 2, 8'h78, 8'h56, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1, 8'h56, 8'h78, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 0, 8'h00, 8'h00, 1'b1};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 0, 8'h00, 8'h00, 1'b0};

        // Reset then idle: flags must sit at their reset values.
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, '0, 1'b0);
            checkVal("idleEmpty", emptyL, 1);
            checkVal("idleLevel", levelL, 0);
        end

        // Table: single-word LSB/MSB ordering, underflow stickiness, overlap.
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].wr, vecs[i].d, vecs[i].rd);
            checkVal($sformatf("vec%0d.empty", i), emptyL, vecs[i].expEmpty);
            checkVal($sformatf("vec%0d.level", i), levelL, vecs[i].expLevel);
            checkVal($sformatf("vec%0d.underflow", i), underflowL, vecs[i].expUn);
            if (!vecs[i].expEmpty) begin
                checkVal($sformatf("vec%0d.doutL", i), doutL, vecs[i].expL);
                checkVal($sformatf("vec%0d.doutM", i), doutM, vecs[i].expM);
            end
            checkOutput();
        end

        // Fill to full, watch flag thresholds, then overflow and drain.
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DP; i++) begin
            step(1'b1, 1'b1, IW'(i), 1'b0);
            checkVal($sformatf("fill%0d.prog_full", i + 1), progFullL, (i + 1) >= TH);
            checkVal($sformatf("fill%0d.almost_full", i + 1), almostFullL, (i + 1) == DP - 1);
            checkVal($sformatf("fill%0d.full", i + 1), fullL, (i + 1) == DP);
        end
        step(1'b1, 1'b1, 16'hFFFF, 1'b0);
        checkVal("overflowSet", overflowL, 1);
        for (int i = 0; i < DP * RT; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
        end
        checkVal("drainedEmpty", emptyL, 1);

        // Full with a same-cycle pop and write: the write must be dropped.
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < DP; i++) begin
            step(1'b1, 1'b1, IW'(16'h0100 + i), 1'b0);
        end
        step(1'b1, 1'b0, '0, 1'b1);
        checkVal("partialStillFull", fullL, 1);
        step(1'b1, 1'b1, 16'hBEEF, 1'b1);
        checkVal("popWriteOverflow", overflowL, 1);
        checkVal("popWriteLevel", levelL, (DP - 1) * RT);
        checkVal("popWriteAlmostFull", almostFullL, 1);
        for (int i = 0; i < (DP - 1) * RT; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
        end

        // Streaming: 100 words through several pointer wraps.
        step(1'b0, 1'b0, '0, 1'b0);
        begin
            int written;
            written = 0;
            for (int cyc = 0; cyc < 260; cyc++) begin
                logic wr;
                wr = ((cyc % 2) == 0) && (written < 100);
                if (wr) written++;
                step(1'b1, wr, IW'($urandom), modelQ.size() > 0);
            end
        end
        checkVal("streamNoUnderflow", underflowL, 0);
        checkVal("streamNoOverflow", overflowL, 0);
        checkVal("streamDrained", emptyL, 1);

        // Reset mid-operation discards everything, including a partial word.
        step(1'b0, 1'b0, '0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b1, IW'(16'hC000 + i), 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, '0, 1'b1);
        end
        step(1'b0, 1'b1, 16'hDEAD, 1'b1);
        checkVal("midResetEmpty", emptyL, 1);
        checkVal("midResetLevel", levelL, 0);
        step(1'b1, 1'b1, 16'h1234, 1'b0);
        checkVal("postResetDoutL", doutL, 8'h34);
        checkVal("postResetDoutM", doutM, 8'h12);
        checkVal("postResetLevel", levelL, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
